// File: rtl/data_mem_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_responder_pkg
// Purpose  : Shared types and constants for the data-memory responder:
//            byte-lane select bus, lane width, FSM encodings, default latency.
// Revision : 1.0 - initial release
// ============================================================================
package data_mem_responder_pkg;

  localparam int c_LANE_WIDTH      = 8;
  localparam int c_NUM_LANES       = 4;
  localparam int c_COUNT_WIDTH     = 4;   // covers LATENCY-1 up to 14
  localparam int c_DEFAULT_LATENCY = 2;

  // One select bit per byte lane; bit n covers data[8n+7:8n]
  typedef logic [c_NUM_LANES-1:0] memSelBus_t;

  typedef enum logic [0:0] {
    MEMRSP_IDLE = 1'b0,
    MEMRSP_WAIT = 1'b1
  } memRspState_t;

endpackage
`default_nettype wire

// File: rtl/data_mem_responder_ram.sv
`default_nettype none
// ============================================================================
// Module   : data_ram_array
// Purpose  : Four byte-wide synchronous arrays with per-lane write enable and
//            a registered, lane-masked read port. Lanes not selected on a read
//            return 8'h00. Read register holds until the next read strobe.
// Revision : 1.0 - initial release
// ============================================================================
module data_ram_array
  import data_mem_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                                clk,
  input  logic                                rst,      // async, active-low
  input  logic [ADDR_WIDTH-1:0]               i_addr,
  input  logic                                i_wrEn,
  input  logic                                i_rdEn,
  input  memSelBus_t                          i_sel,
  input  logic [c_NUM_LANES*c_LANE_WIDTH-1:0] i_wdata,
  output logic [c_NUM_LANES*c_LANE_WIDTH-1:0] o_rdata
);

  localparam int c_DEPTH = 1 << ADDR_WIDTH;

  for (genvar n = 0; n < c_NUM_LANES; n++) begin : g_lane
    logic [c_LANE_WIDTH-1:0] r_mem [0:c_DEPTH-1];
    logic [c_LANE_WIDTH-1:0] r_q;

    // Lane storage: written only when this lane is selected on a write strobe
    always_ff @(posedge clk) begin
      if (i_wrEn && i_sel[n]) begin
        r_mem[i_addr] <= i_wdata[n*c_LANE_WIDTH +: c_LANE_WIDTH];
      end
    end

    // Lane read register: masked capture on a read strobe, otherwise held
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_q <= '0;
      end else if (i_rdEn) begin
        r_q <= i_sel[n] ? r_mem[i_addr] : '0;
      end
    end

    assign o_rdata[n*c_LANE_WIDTH +: c_LANE_WIDTH] = r_q;
  end

endmodule
`default_nettype wire

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_responder
// Purpose  : MEM-stage memory responder. Accepts one request at a time,
//            waits LATENCY edges, then performs a byte-lane read or write and
//            pulses o_ready for one cycle. o_busy stalls the pipeline.
// Revision : 1.0 - initial release
// ============================================================================
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int LATENCY    = c_DEFAULT_LATENCY
) (
  input  logic                  clk,
  input  logic                  rst,      // async, active-low
  input  logic                  i_re,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  memSelBus_t            i_sel,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic                  o_busy,
  output logic                  o_ready,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  // Counter starts at LATENCY-1 so completion lands LATENCY edges after accept
  localparam logic [c_COUNT_WIDTH-1:0] c_LOAD = c_COUNT_WIDTH'(LATENCY - 1);

  memRspState_t            r_state;
  logic [c_COUNT_WIDTH-1:0] r_count;
  logic                    r_ready;
  logic                    r_isWrite;
  logic [ADDR_WIDTH-1:0]   r_addr;
  memSelBus_t              r_sel;
  logic [DATA_WIDTH-1:0]   r_wdata;

  logic w_complete;
  logic w_wrEn;
  logic w_rdEn;

  // The completion edge is the one where WAIT sees an exhausted counter
  assign w_complete = (r_state == MEMRSP_WAIT) && (r_count == '0);
  assign w_wrEn     = w_complete &&  r_isWrite;
  assign w_rdEn     = w_complete && !r_isWrite;

  // Request FSM: capture on accept, count down, then complete and strobe ready
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= MEMRSP_IDLE;
      r_count   <= '0;
      r_ready   <= 1'b0;
      r_isWrite <= 1'b0;
      r_addr    <= '0;
      r_sel     <= '0;
      r_wdata   <= '0;
    end else begin
      r_ready <= 1'b0;
      case (r_state)
        MEMRSP_IDLE: begin
          if (i_re || i_we) begin
            // A simultaneous read+write request is treated as a write
            r_isWrite <= i_we;
            r_addr    <= i_addr;
            r_sel     <= i_sel;
            r_wdata   <= i_wdata;
            r_count   <= c_LOAD;
            r_state   <= MEMRSP_WAIT;
          end
        end
        MEMRSP_WAIT: begin
          if (r_count != '0) begin
            r_count <= r_count - 1'b1;
          end else begin
            r_ready <= 1'b1;
            r_state <= MEMRSP_IDLE;
          end
        end
        default: r_state <= MEMRSP_IDLE;
      endcase
    end
  end

  data_ram_array #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .i_addr  (r_addr),
    .i_wrEn  (w_wrEn),
    .i_rdEn  (w_rdEn),
    .i_sel   (r_sel),
    .i_wdata (r_wdata),
    .o_rdata (o_rdata)
  );

  assign o_busy  = (r_state == MEMRSP_WAIT);
  assign o_ready = r_ready;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_mem_responder
// Purpose  : Directed self-checking bench for data_mem_responder. Two
//            instances: LATENCY=2 (main) and LATENCY=1.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        re = 1'b0;
  logic        we = 1'b0;
  logic [9:0]  addr = '0;
  logic [3:0]  sel = '0;
  logic [31:0] wdata = '0;
  logic        useL1 = 1'b0;

  logic        busy2, ready2, busy1, ready1;
  logic [31:0] rdata2, rdata1;

  logic        re2, we2, re1, we1;
  logic        obsBusy, obsReady;
  logic [31:0] obsRdata;

  int          testCount = 0;
  int          failCount = 0;
  logic [31:0] lastRd [2];

  assign re2 = re & ~useL1;
  assign we2 = we & ~useL1;
  assign re1 = re &  useL1;
  assign we1 = we &  useL1;

  assign obsBusy  = useL1 ? busy1  : busy2;
  assign obsReady = useL1 ? ready1 : ready2;
  assign obsRdata = useL1 ? rdata1 : rdata2;

  always #5 clk = ~clk;

  data_mem_responder #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .LATENCY(2)) u_dutL2 (
    .clk(clk), .rst(rst), .i_re(re2), .i_we(we2), .i_addr(addr), .i_sel(sel),
    .i_wdata(wdata), .o_busy(busy2), .o_ready(ready2), .o_rdata(rdata2)
  );

  data_mem_responder #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .LATENCY(1)) u_dutL1 (
    .clk(clk), .rst(rst), .i_re(re1), .i_we(we1), .i_addr(addr), .i_sel(sel),
    .i_wdata(wdata), .o_busy(busy1), .o_ready(ready1), .o_rdata(rdata1)
  );

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testCount++;
    if (obs !== exp) begin
      failCount++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One cycle forward, sampling 1 ns after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one op and check busy/ready timing edge by edge. Ends in the
  // o_ready cycle so the next call exercises back-to-back acceptance.
  // With inject set, a conflicting write to 0x030 is driven while busy.
  task automatic doOp(input string tag, input logic isW, input logic isR,
                      input logic [9:0] a, input logic [3:0] s,
                      input logic [31:0] d, input logic [31:0] expRd,
                      input bit inject);
    int lat;
    lat = useL1 ? 1 : 2;
    checkVal({tag, "_idle"}, {31'd0, obsBusy}, 32'd0);
    we = isW; re = isR; addr = a; sel = s; wdata = d;
    step();  // accept edge
    we = 1'b0; re = 1'b0;
    for (int k = 0; k < lat; k++) begin
      if (inject) begin
        we = 1'b1; addr = 10'h030; sel = 4'hF; wdata = 32'h12345678;
      end
      checkVal({tag, "_busy"},   {31'd0, obsBusy},  32'd1);
      checkVal({tag, "_noRdy"},  {31'd0, obsReady}, 32'd0);
      step();
    end
    checkVal({tag, "_ready"},  {31'd0, obsReady}, 32'd1);
    checkVal({tag, "_free"},   {31'd0, obsBusy},  32'd0);
    if (isW) begin
      checkVal({tag, "_rdHeld"}, obsRdata, lastRd[useL1]);
    end else begin
      checkVal({tag, "_rdata"}, obsRdata, expRd);
      lastRd[useL1] = expRd;
    end
    if (inject) begin
      we = 1'b0;
      step();
      checkVal({tag, "_onePulse"}, {31'd0, obsReady}, 32'd0);
      checkVal({tag, "_stayIdle"}, {31'd0, obsBusy},  32'd0);
    end
  endtask

  initial begin
    lastRd[0] = '0;
    lastRd[1] = '0;
    #12;
    // Reset state on both instances
    checkVal("rst_busy2",  {31'd0, busy2},  32'd0);
    checkVal("rst_ready2", {31'd0, ready2}, 32'd0);
    checkVal("rst_rdata2", rdata2, 32'd0);
    checkVal("rst_busy1",  {31'd0, busy1},  32'd0);
    checkVal("rst_rdata1", rdata1, 32'd0);
    rst = 1'b1;
    step();

    // 1: basic write then read
    doOp("t1_wr", 1'b1, 1'b0, 10'h010, 4'hF, 32'hDEADBEEF, 32'h0, 1'b0);
    doOp("t1_rd", 1'b0, 1'b1, 10'h010, 4'hF, 32'h0, 32'hDEADBEEF, 1'b0);

    // 2: partial-lane write and masked reads (back-to-back issue)
    doOp("t2_wr",   1'b1, 1'b0, 10'h020, 4'hF, 32'hDEADBEEF, 32'h0, 1'b0);
    doOp("t2_wrB1", 1'b1, 1'b0, 10'h020, 4'b0010, 32'h0000AA00, 32'h0, 1'b0);
    doOp("t2_rdF",  1'b0, 1'b1, 10'h020, 4'hF, 32'h0, 32'hDEADAAEF, 1'b0);
    doOp("t2_rd5",  1'b0, 1'b1, 10'h020, 4'b0101, 32'h0, 32'h00AD00EF, 1'b0);
    // Read+write together is a write; rdata must stay at last read value
    doOp("t2_rw",   1'b1, 1'b1, 10'h021, 4'hF, 32'h0BADF00D, 32'h0, 1'b0);
    doOp("t2_rdRw", 1'b0, 1'b1, 10'h021, 4'hF, 32'h0, 32'h0BADF00D, 1'b0);

    // 3: request while busy is ignored; in-flight op uses captured inputs
    doOp("t3_pre",  1'b1, 1'b0, 10'h030, 4'hF, 32'hCAFEF00D, 32'h0, 1'b0);
    doOp("t3_op",   1'b1, 1'b0, 10'h050, 4'hF, 32'h55AA33CC, 32'h0, 1'b1);
    doOp("t3_rd30", 1'b0, 1'b1, 10'h030, 4'hF, 32'h0, 32'hCAFEF00D, 1'b0);
    doOp("t3_rd50", 1'b0, 1'b1, 10'h050, 4'hF, 32'h0, 32'h55AA33CC, 1'b0);

    // 5: reset mid-WAIT aborts the write
    doOp("t5_pre", 1'b1, 1'b0, 10'h040, 4'hF, 32'hAAAA5555, 32'h0, 1'b0);
    step();
    we = 1'b1; addr = 10'h040; sel = 4'hF; wdata = 32'h11111111;
    step();
    we = 1'b0;
    checkVal("t5_busyBefore", {31'd0, busy2}, 32'd1);
    #2 rst = 1'b0;
    #1;
    checkVal("t5_busyRst",  {31'd0, busy2},  32'd0);
    checkVal("t5_readyRst", {31'd0, ready2}, 32'd0);
    checkVal("t5_rdataRst", rdata2, 32'd0);
    lastRd[0] = '0;
    lastRd[1] = '0;
    step();
    step();
    checkVal("t5_readyHeld", {31'd0, ready2}, 32'd0);
    rst = 1'b1;
    step();
    doOp("t5_rd", 1'b0, 1'b1, 10'h040, 4'hF, 32'h0, 32'hAAAA5555, 1'b0);
    step();

    // 6: LATENCY=1 instance
    useL1 = 1'b1;
    doOp("t6_wr",   1'b1, 1'b0, 10'h008, 4'hF, 32'h13579BDF, 32'h0, 1'b0);
    doOp("t6_rd",   1'b0, 1'b1, 10'h008, 4'hF, 32'h0, 32'h13579BDF, 1'b0);
    doOp("t6_wr0",  1'b1, 1'b0, 10'h008, 4'h0, 32'hFFFFFFFF, 32'h0, 1'b0);
    doOp("t6_rdB",  1'b0, 1'b1, 10'h008, 4'b1000, 32'h0, 32'h13000000, 1'b0);
    doOp("t6_rd0",  1'b0, 1'b1, 10'h008, 4'h0, 32'h0, 32'h00000000, 1'b0);
    doOp("t6_rdF",  1'b0, 1'b1, 10'h008, 4'hF, 32'h0, 32'h13579BDF, 1'b0);
    step();
    checkVal("t6_readyDrop", {31'd0, ready1}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

  // Watchdog against a stuck run
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Memory-side responder for the CPU MEM stage. It is the other end of the `mem_memReadEnable` / `mem_memWriteEnable` / `mem_memAddr` / `mem_memSel` interface.
- It accepts one word-addressed request at a time, waits a fixed number of cycles, then performs the byte-lane read or write and pulses a completion strobe.
- The pipeline uses `o_busy` to stall MEM.
- Sits beside the CPU top next to the instruction ROM, in the testbench or SoC wrapper.

Parameters:
- `ADDR_WIDTH`, 10: word-address bits; depth is 2**ADDR_WIDTH words.
- `DATA_WIDTH`, 32: word width; fixed at 32, with 4 byte lanes.
- `LATENCY`, 2: clock edges from the request-accept edge to the completion edge; legal range 1..15.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `i_re`  in  1  read request.
- `i_we`  in  1  write request.
- `i_addr`  in  ADDR_WIDTH  word address (`mem_memAddr` low bits).
- `i_sel`  in  4  byte-lane select; bit n selects data[8n+7:8n].
- `i_wdata`  in  32  write data.
- `o_busy`  out  1  request in flight; new requests are not accepted.
- `o_ready`  out  1  one-cycle completion pulse.
- `o_rdata`  out  32  read data, valid while `o_ready` is high and held until the next completion.

Behaviour:
- Reset (`rst`=0, asynchronous):
  - state=IDLE, counter=0, `o_busy`=0, `o_ready`=0, `o_rdata`=0, captured request registers=0.
  - Array contents are not reset.
- States:
  - IDLE: `o_busy`=0.
  - WAIT: `o_busy`=1, implemented combinationally as state==WAIT.
- Accept:
  - In IDLE, at the rising edge where (`i_re` | `i_we`)=1, capture `i_addr`, `i_sel`, `i_wdata` and the op.
  - Load counter=LATENCY-1 and go to WAIT.
  - If `i_we` and `i_re` are both 1, the op is a write and the read is ignored.
- WAIT:
  - counter≠0: decrement.
  - counter==0 (the completion edge): execute the op, set `o_ready`<=1, go to IDLE.
- `o_ready` is high for exactly the one cycle after the completion edge. It is cleared on the next edge unless another completion occurs.
- Latency: request sampled at edge E0, completion at edge E(LATENCY). LATENCY=1 gives `o_ready` in the cycle right after acceptance.
- Throughput: the IDLE cycle in which `o_ready` is high may accept a new request, giving one op per LATENCY+1 cycles.
- Write:
  - Only lanes with `i_sel`[n]=1 are updated.
  - `i_sel`=0000 changes nothing but still completes with an `o_ready` pulse.
  - `o_rdata` is unchanged on a write completion.
- Read:
  - `o_rdata` lane n = array lane n if `i_sel`[n]=1, else 8'h00.
  - `i_sel`=0000 returns 0.
- Requests while `o_busy`=1 are ignored, not queued. The initiator holds its request until `o_busy`=0.
- Input changes after acceptance have no effect on the in-flight op, because the captured copy is used.
- Address is exactly ADDR_WIDTH bits, so no out-of-range case exists. Upper bits of the CPU address are dropped by the wrapper.
- Read after write to the same address in consecutive ops returns the new data.
- Reset mid-WAIT: the op is aborted, no array write occurs, and `o_ready` stays 0.

Decomposition:
- Shared define file gets: `MEM_SEL_BUS` [3:0], byte-lane width 8, state encodings `MEMRSP_IDLE`/`MEMRSP_WAIT`, and default LATENCY.
- One sub-module: `data_ram_array`.
  - Four 8-bit × 2**ADDR_WIDTH synchronous arrays.
  - Per-lane write enable.
  - Registered read port addressed by the captured address.
  - Updated only on the completion edge.
- The FSM, counter and output registers stay in `data_mem_responder`.

Test Plan:
1. Reset, then a write with addr=0x010, sel=1111, wdata=0xDEADBEEF, LATENCY=2, then a read of addr=0x010, sel=1111 → each `o_ready` arrives exactly 2 edges after its accept edge; read gives `o_rdata`=0xDEADBEEF; `o_busy`=1 for exactly 2 cycles per op.
2. Write 0xDEADBEEF to addr 0x020, then write sel=0010, wdata=0x0000AA00 to addr 0x020, then read with sel=1111 → 0xDEADAABEF is wrong; required result is 0xDEADAAEF. A read of the same address with sel=0101 → 0x00AD00EF.
3. While `o_busy`=1, drive `i_we` to addr 0x030 with data 0x12345678 → ignored; a later read of 0x030 returns the prior contents; exactly one `o_ready` pulse for the original op.
4. Back-to-back: assert a new request in the `o_ready` cycle → accepted that edge; next `o_ready` arrives LATENCY edges later; sustained rate is one completion per 3 cycles at LATENCY=2.
5. Write to 0x040 with data 0x11111111, then assert `rst`=0 asynchronously mid-WAIT → `o_busy`, `o_ready` and `o_rdata` go to 0 immediately; a subsequent read of 0x040 shows the old value.
6. LATENCY=1 build: a read accepted at E0 → `o_ready` high in the cycle after E1, with correct data; a write with sel=0000 → `o_ready` pulses and memory is unchanged.
